// File: rtl/hazard3_bus_arbiter_1port_if.sv
// Bundle of the fetch (I) and load/store (D) request ports plus the
// AHB-Lite master port handled by hazard3_bus_arbiter_1port.
// The master modport is the arbiter's own view (it is the AHB master);
// the slave modport is the view of everything around it: core and bus.
interface hazard3_bus_arbiter_1port_if #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
);
   // Fetch requester
   logic              aph_req_i;
   logic              aph_panic_i;
   logic [W_ADDR-1:0] haddr_i;
   logic [2:0]        hsize_i;
   logic              priv_i;
   logic              aph_ready_i;
   logic              dph_ready_i;
   logic              dph_err_i;
   logic [W_DATA-1:0] rdata_i;

   // Load/store requester
   logic              aph_req_d;
   logic              aph_excl_d;
   logic              hwrite_d;
   logic [W_ADDR-1:0] haddr_d;
   logic [2:0]        hsize_d;
   logic              priv_d;
   logic [W_DATA-1:0] wdata_d;
   logic              aph_ready_d;
   logic              dph_ready_d;
   logic              dph_err_d;
   logic              dph_exokay_d;
   logic [W_DATA-1:0] rdata_d;

   // AHB-Lite master port
   logic [W_ADDR-1:0] haddr;
   logic              hwrite;
   logic [1:0]        htrans;
   logic [2:0]        hsize;
   logic [2:0]        hburst;
   logic [3:0]        hprot;
   logic              hmastlock;
   logic              hexcl;
   logic              hready;
   logic              hresp;
   logic              hexokay;
   logic [W_DATA-1:0] hwdata;
   logic [W_DATA-1:0] hrdata;

   modport master (
      input  aph_req_i, aph_panic_i, haddr_i, hsize_i, priv_i,
      output aph_ready_i, dph_ready_i, dph_err_i, rdata_i,
      input  aph_req_d, aph_excl_d, hwrite_d, haddr_d, hsize_d, priv_d, wdata_d,
      output aph_ready_d, dph_ready_d, dph_err_d, dph_exokay_d, rdata_d,
      output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hexcl, hwdata,
      input  hready, hresp, hexokay, hrdata
   );

   modport slave (
      output aph_req_i, aph_panic_i, haddr_i, hsize_i, priv_i,
      input  aph_ready_i, dph_ready_i, dph_err_i, rdata_i,
      output aph_req_d, aph_excl_d, hwrite_d, haddr_d, hsize_d, priv_d, wdata_d,
      input  aph_ready_d, dph_ready_d, dph_err_d, dph_exokay_d, rdata_d,
      input  haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hexcl, hwdata,
      output hready, hresp, hexokay, hrdata
   );
endinterface

// File: rtl/hazard3_bus_arbiter_1port.sv
// Single-port bus arbiter: merges Hazard3 instruction fetch (I) and
// load/store (D) requests onto one AHB-Lite master port. D normally wins,
// except for urgent fetches or after STARVE_LIMIT fetch address phases lost
// to D. A stalled address phase is locked to its owner so the bus sees
// stable controls, and data-phase responses go only to the side that owns
// the current data phase.
module hazard3_bus_arbiter_1port #(
   parameter int W_ADDR       = 32,
   parameter int W_DATA       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int W_STARVE     = 3
) (
   input logic                         clk,
   input logic                         rst_n,
   hazard3_bus_arbiter_1port_if.master bus
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   localparam logic [1:0]          HTRANS_IDLE = 2'b00;
   localparam logic [1:0]          HTRANS_NSEQ = 2'b10;
   localparam logic [W_STARVE-1:0] STARVE_MAX  = '1;
   localparam logic [W_STARVE-1:0] STARVE_THR  = W_STARVE'(STARVE_LIMIT);

   owner_e              dph_owner_q, dph_owner_d;
   owner_e              lock_sel_q, lock_sel_d;
   logic                aph_lock_q, aph_lock_d;
   logic [W_STARVE-1:0] starve_cnt_q, starve_cnt_d;

   owner_e              grant;
   logic                starved;
   logic                aph_active;
   logic                sel_d;
   logic                aph_ready_i_w, aph_ready_d_w;
   logic [W_ADDR-1:0]   haddr_sel;
   logic [W_DATA-1:0]   rdata_w;

   assign starved = (STARVE_LIMIT != 0) && (starve_cnt_q >= STARVE_THR);

   // Grant: a locked (stalled) address phase keeps its owner; otherwise urgent
   // or starved fetch, then load/store, then ordinary fetch.
   always_comb begin
      grant = OWN_NONE;
      if (aph_lock_q)
         grant = lock_sel_q;
      else if (bus.aph_req_i && (bus.aph_panic_i || starved))
         grant = OWN_I;
      else if (bus.aph_req_d)
         grant = OWN_D;
      else if (bus.aph_req_i)
         grant = OWN_I;
   end

   // Address-phase mux and handshakes; everything is quiet while in reset.
   always_comb begin
      sel_d      = (grant == OWN_D);
      aph_active = rst_n && (((grant == OWN_I) && bus.aph_req_i) ||
                             ((grant == OWN_D) && bus.aph_req_d));
      haddr_sel  = sel_d ? bus.haddr_d : bus.haddr_i;

      bus.htrans    = aph_active ? HTRANS_NSEQ : HTRANS_IDLE;
      bus.haddr     = haddr_sel;
      bus.hsize     = sel_d ? bus.hsize_d : bus.hsize_i;
      bus.hwrite    = sel_d && bus.hwrite_d;
      bus.hexcl     = sel_d && bus.aph_excl_d;
      bus.hprot     = {2'b00, (sel_d ? bus.priv_d : bus.priv_i), sel_d};
      bus.hburst    = 3'b000;
      bus.hmastlock = 1'b0;

      aph_ready_i_w   = bus.hready && aph_active && (grant == OWN_I);
      aph_ready_d_w   = bus.hready && aph_active && (grant == OWN_D);
      bus.aph_ready_i = aph_ready_i_w;
      bus.aph_ready_d = aph_ready_d_w;
   end

   // Data-phase responses steered to the current data-phase owner. The D
   // error is visible in both error cycles so a chasing D access can be
   // squashed before its address phase completes.
   always_comb begin
      bus.dph_ready_i  = rst_n && bus.hready && (dph_owner_q == OWN_I);
      bus.dph_ready_d  = rst_n && bus.hready && (dph_owner_q == OWN_D);
      bus.dph_err_i    = rst_n && bus.hready && bus.hresp && (dph_owner_q == OWN_I);
      bus.dph_err_d    = rst_n && bus.hresp && (dph_owner_q == OWN_D);
      bus.dph_exokay_d = rst_n && bus.hexokay && (dph_owner_q == OWN_D);
   end

   assign rdata_w     = bus.hrdata;
   assign bus.rdata_i = rdata_w;
   assign bus.rdata_d = rdata_w;
   assign bus.hwdata  = bus.wdata_d;

   // Next state: data-phase owner advances with hready, the lock captures a
   // stalled address phase, and the starvation counter tracks fetch losses.
   always_comb begin
      dph_owner_d  = dph_owner_q;
      aph_lock_d   = aph_lock_q;
      lock_sel_d   = lock_sel_q;
      starve_cnt_d = starve_cnt_q;

      if (bus.hready) begin
         dph_owner_d = aph_active ? grant : OWN_NONE;
         aph_lock_d  = 1'b0;
      end else if (aph_active) begin
         aph_lock_d  = 1'b1;
         lock_sel_d  = grant;
      end

      if (aph_ready_i_w)
         starve_cnt_d = '0;
      else if (aph_ready_d_w && bus.aph_req_i && (starve_cnt_q != STARVE_MAX))
         starve_cnt_d = starve_cnt_q + 1'b1;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dph_owner_q  <= OWN_NONE;
         aph_lock_q   <= 1'b0;
         lock_sel_q   <= OWN_I;
         starve_cnt_q <= '0;
      end else begin
         dph_owner_q  <= dph_owner_d;
         aph_lock_q   <= aph_lock_d;
         lock_sel_q   <= lock_sel_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard3_bus_arbiter_1port.sv
// Bench for hazard3_bus_arbiter_1port: directed scenarios followed by
// random traffic, all checked against a behavioural model of the arbiter.
module tb_hazard3_bus_arbiter_1port;
   localparam int W_ADDR       = 32;
   localparam int W_DATA       = 32;
   localparam int STARVE_LIMIT = 4;
   localparam int W_STARVE     = 3;
   localparam int STARVE_SAT   = (1 << W_STARVE) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard3_bus_arbiter_1port_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus ();

   hazard3_bus_arbiter_1port #(
      .W_ADDR(W_ADDR), .W_DATA(W_DATA),
      .STARVE_LIMIT(STARVE_LIMIT), .W_STARVE(W_STARVE)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.master)
   );

   int total = 0;
   int bad   = 0;

   // Model: side numbers 0 = nobody, 1 = fetch, 2 = load/store.
   int m_dph    = 0;  // side whose data phase is in progress
   int m_stall  = 0;  // side whose address phase is stuck waiting for hready
   int m_starve = 0;  // fetch address phases lost to load/store in a row

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_winner();
      if (m_stall != 0) return m_stall;
      if (bus.aph_req_i && (bus.aph_panic_i || (STARVE_LIMIT > 0 && m_starve >= STARVE_LIMIT))) return 1;
      if (bus.aph_req_d) return 2;
      if (bus.aph_req_i) return 1;
      return 0;
   endfunction

   function automatic bit model_presenting(input int w);
      return rst_n && ((w == 1 && bus.aph_req_i) || (w == 2 && bus.aph_req_d));
   endfunction

   // Compare every output against the model for the current inputs.
   task automatic check_all();
      int w;
      bit act;
      #1;
      w   = model_winner();
      act = model_presenting(w);
      chk("htrans", 64'(bus.htrans), act ? 64'd2 : 64'd0);
      if (act) begin
         chk("haddr",  64'(bus.haddr),  64'(w == 2 ? bus.haddr_d : bus.haddr_i));
         chk("hsize",  64'(bus.hsize),  64'(w == 2 ? bus.hsize_d : bus.hsize_i));
         chk("hprot",  64'(bus.hprot),  64'({2'b00, (w == 2 ? bus.priv_d : bus.priv_i), (w == 2)}));
         chk("hwrite", 64'(bus.hwrite), 64'(w == 2 && bus.hwrite_d));
         chk("hexcl",  64'(bus.hexcl),  64'(w == 2 && bus.aph_excl_d));
      end
      chk("hburst",       64'(bus.hburst),       64'd0);
      chk("hmastlock",    64'(bus.hmastlock),    64'd0);
      chk("aph_ready_i",  64'(bus.aph_ready_i),  64'(bus.hready && act && w == 1));
      chk("aph_ready_d",  64'(bus.aph_ready_d),  64'(bus.hready && act && w == 2));
      chk("dph_ready_i",  64'(bus.dph_ready_i),  64'(rst_n && bus.hready && m_dph == 1));
      chk("dph_ready_d",  64'(bus.dph_ready_d),  64'(rst_n && bus.hready && m_dph == 2));
      chk("dph_err_i",    64'(bus.dph_err_i),    64'(rst_n && bus.hready && bus.hresp && m_dph == 1));
      chk("dph_err_d",    64'(bus.dph_err_d),    64'(rst_n && bus.hresp && m_dph == 2));
      chk("dph_exokay_d", 64'(bus.dph_exokay_d), 64'(rst_n && bus.hexokay && m_dph == 2));
      chk("rdata_i",      64'(bus.rdata_i),      64'(bus.hrdata));
      chk("rdata_d",      64'(bus.rdata_d),      64'(bus.hrdata));
      chk("hwdata",       64'(bus.hwdata),       64'(bus.wdata_d));
   endtask

   // Clock edge: advance the model with the inputs the DUT just sampled.
   task automatic tick();
      int w;
      bit act;
      @(posedge clk);
      w   = model_winner();
      act = model_presenting(w);
      if (!rst_n) begin
         m_dph = 0; m_stall = 0; m_starve = 0;
      end else begin
         if (bus.hready && act && w == 1)
            m_starve = 0;
         else if (bus.hready && act && w == 2 && bus.aph_req_i)
            m_starve = (m_starve < STARVE_SAT) ? m_starve + 1 : STARVE_SAT;
         if (bus.hready) begin
            m_dph   = act ? w : 0;
            m_stall = 0;
         end else if (act) begin
            m_stall = w;
         end
      end
      @(negedge clk);
   endtask

   task automatic step();
      check_all();
      tick();
   endtask

   initial begin
      bus.aph_req_i = 1'b1; bus.aph_panic_i = 1'b0; bus.haddr_i = '0; bus.hsize_i = 3'd2; bus.priv_i = 1'b0;
      bus.aph_req_d = 1'b1; bus.aph_excl_d = 1'b0; bus.hwrite_d = 1'b0; bus.haddr_d = '0;
      bus.hsize_d = 3'd2; bus.priv_d = 1'b0; bus.wdata_d = 32'h1234_5678;
      bus.hready = 1'b1; bus.hresp = 1'b0; bus.hexokay = 1'b1; bus.hrdata = 32'h0bad_f00d;
      rst_n = 1'b0;
      @(negedge clk);

      // Reset: requests and responses present, outputs must stay quiet.
      step();
      check_all();
      chk("rst_htrans", 64'(bus.htrans), 64'd0);
      chk("rst_aph_ready_i", 64'(bus.aph_ready_i), 64'd0);
      chk("rst_dph_exokay_d", 64'(bus.dph_exokay_d), 64'd0);
      tick();
      rst_n = 1'b1; bus.aph_req_i = 1'b0; bus.aph_req_d = 1'b0; bus.hexokay = 1'b0;

      // Single fetch, then its data phase.
      bus.aph_req_i = 1'b1; bus.haddr_i = 32'h100; bus.priv_i = 1'b1;
      check_all();
      chk("f_haddr", 64'(bus.haddr), 64'h100);
      chk("f_hprot", 64'(bus.hprot), 64'b0010);
      chk("f_aph_ready_i", 64'(bus.aph_ready_i), 64'd1);
      tick();
      bus.aph_req_i = 1'b0; bus.hrdata = 32'hcafe_0001;
      check_all();
      chk("f_dph_ready_i", 64'(bus.dph_ready_i), 64'd1);
      chk("f_rdata_i", 64'(bus.rdata_i), 64'hcafe_0001);
      tick();

      // Starvation: D wins four times, then I is forced through once.
      bus.aph_req_i = 1'b1; bus.haddr_i = 32'h104; bus.priv_i = 1'b0;
      bus.aph_req_d = 1'b1; bus.haddr_d = 32'h2000; bus.hwrite_d = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_all();
         chk("sv_d_wins", 64'(bus.aph_ready_d), 64'd1);
         chk("sv_i_waits", 64'(bus.aph_ready_i), 64'd0);
         chk("sv_haddr", 64'(bus.haddr), 64'h2000);
         tick();
      end
      check_all();
      chk("sv_i_forced", 64'(bus.aph_ready_i), 64'd1);
      chk("sv_i_haddr", 64'(bus.haddr), 64'h104);
      tick();
      check_all();
      chk("sv_d_again", 64'(bus.aph_ready_d), 64'd1);
      tick();
      bus.aph_req_i = 1'b0; bus.aph_req_d = 1'b0; bus.hwrite_d = 1'b0;
      step();

      // Stalled fetch address phase must not move under D requests or panic.
      bus.aph_req_i = 1'b1; bus.haddr_i = 32'h40; bus.hready = 1'b0;
      check_all();
      chk("st_haddr0", 64'(bus.haddr), 64'h40);
      tick();
      for (int k = 0; k < 2; k++) begin
         bus.aph_req_d = 1'b1; bus.haddr_d = 32'h5000; bus.aph_panic_i = (k == 0);
         check_all();
         chk("st_haddr", 64'(bus.haddr), 64'h40);
         chk("st_htrans", 64'(bus.htrans), 64'd2);
         chk("st_no_ready", 64'(bus.aph_ready_i), 64'd0);
         tick();
      end
      bus.hready = 1'b1; bus.aph_panic_i = 1'b0;
      check_all();
      chk("st_release", 64'(bus.aph_ready_i), 64'd1);
      chk("st_haddr_rel", 64'(bus.haddr), 64'h40);
      tick();
      bus.aph_req_i = 1'b0; bus.aph_req_d = 1'b0;
      step();

      // Load with a two-cycle error response.
      bus.aph_req_d = 1'b1; bus.haddr_d = 32'h3000;
      step();
      bus.aph_req_d = 1'b0; bus.hresp = 1'b1; bus.hready = 1'b0;
      check_all();
      chk("er1_err_d", 64'(bus.dph_err_d), 64'd1);
      chk("er1_ready_d", 64'(bus.dph_ready_d), 64'd0);
      chk("er1_err_i", 64'(bus.dph_err_i), 64'd0);
      tick();
      bus.hready = 1'b1;
      check_all();
      chk("er2_err_d", 64'(bus.dph_err_d), 64'd1);
      chk("er2_ready_d", 64'(bus.dph_ready_d), 64'd1);
      chk("er2_err_i", 64'(bus.dph_err_i), 64'd0);
      tick();
      bus.hresp = 1'b0;

      // Exclusive load with exokay in its data phase.
      bus.aph_req_d = 1'b1; bus.aph_excl_d = 1'b1; bus.haddr_d = 32'h3004;
      check_all();
      chk("ex_hexcl", 64'(bus.hexcl), 64'd1);
      tick();
      bus.aph_req_d = 1'b0; bus.aph_excl_d = 1'b0; bus.hexokay = 1'b1;
      check_all();
      chk("ex_exokay", 64'(bus.dph_exokay_d), 64'd1);
      chk("ex_ready_d", 64'(bus.dph_ready_d), 64'd1);
      tick();
      bus.hexokay = 1'b0;

      // Reset arriving while a fetch is stalled and locked.
      bus.aph_req_i = 1'b1; bus.haddr_i = 32'h80; bus.hready = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      check_all();
      chk("rs_htrans", 64'(bus.htrans), 64'd0);
      chk("rs_aph_ready_i", 64'(bus.aph_ready_i), 64'd0);
      tick();
      rst_n = 1'b1; bus.aph_req_i = 1'b0; bus.hready = 1'b1;
      check_all();
      chk("rs_idle", 64'(bus.htrans), 64'd0);
      chk("rs_dph_ready_i", 64'(bus.dph_ready_i), 64'd0);
      chk("rs_dph_ready_d", 64'(bus.dph_ready_d), 64'd0);
      tick();
      bus.aph_req_i = 1'b1; bus.haddr_i = 32'h90;
      check_all();
      chk("rs_fresh_grant", 64'(bus.aph_ready_i), 64'd1);
      chk("rs_fresh_haddr", 64'(bus.haddr), 64'h90);
      tick();

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         rst_n           = ($urandom_range(0, 99) != 0);
         bus.aph_req_i   = $urandom_range(0, 1) == 1;
         bus.aph_panic_i = ($urandom_range(0, 7) == 0);
         bus.haddr_i     = $urandom;
         bus.hsize_i     = 3'($urandom_range(0, 2));
         bus.priv_i      = $urandom_range(0, 1) == 1;
         bus.aph_req_d   = $urandom_range(0, 1) == 1;
         bus.aph_excl_d  = ($urandom_range(0, 3) == 0);
         bus.hwrite_d    = $urandom_range(0, 1) == 1;
         bus.haddr_d     = $urandom;
         bus.hsize_d     = 3'($urandom_range(0, 2));
         bus.priv_d      = $urandom_range(0, 1) == 1;
         bus.wdata_d     = $urandom;
         bus.hready      = ($urandom_range(0, 3) != 0);
         bus.hresp       = ($urandom_range(0, 7) == 0);
         bus.hexokay     = ($urandom_range(0, 3) == 0);
         bus.hrdata      = $urandom;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hazard3_bus_arbiter_1port.md
Name: hazard3_bus_arbiter_1port

Overview:
- Merges the core's instruction-fetch and load/store bus request interfaces onto one AHB-Lite master port, for single-port Hazard3 builds.
- Sits between hazard3_core and the system bus, and decides which requester owns each address phase.
- Tracks the owner of the outstanding data phase and routes the ready, error and exokay responses back to that owner only.
- Guarantees AHB-Lite address-phase stability while the bus is stalled, and bounds fetch starvation under load/store-heavy traffic.

Parameters:
- W_ADDR, 32, address width.
- W_DATA, 32, data width.
- STARVE_LIMIT, 4, number of consecutive fetch address phases lost to D before I is forced to win. 0 disables the override.
- W_STARVE, 3, width of the starvation counter. Must satisfy 2^W_STARVE > STARVE_LIMIT.

Ports:
- clk  in  1  clock, all state on the rising edge
- rst_n  in  1  synchronous active-low reset
- aph_req_i / aph_panic_i  in  1 / 1  fetch request / urgent-fetch hint (I takes priority)
- haddr_i / hsize_i / priv_i  in  W_ADDR / 3 / 1  fetch address-phase controls
- aph_ready_i / dph_ready_i / dph_err_i  out  1 / 1 / 1  fetch handshakes
- rdata_i  out  W_DATA  fetch read data
- aph_req_d / aph_excl_d / hwrite_d  in  1 / 1 / 1  load/store request / exclusive / write
- haddr_d / hsize_d / priv_d  in  W_ADDR / 3 / 1  load/store address-phase controls
- wdata_d  in  W_DATA  store data (data phase)
- aph_ready_d / dph_ready_d / dph_err_d / dph_exokay_d  out  1 / 1 / 1 / 1  load/store handshakes
- rdata_d  out  W_DATA  load read data
- haddr / hwrite / htrans / hsize  out  W_ADDR / 1 / 2 / 3  AHB address phase
- hburst / hprot / hmastlock / hexcl  out  3 / 4 / 1 / 1  AHB attributes
- hready / hresp / hexokay  in  1 / 1 / 1  AHB responses
- hwdata / hrdata  out / in  W_DATA  AHB data

Behaviour:
- State registers:
  - dph_owner ∈ {NONE, I, D}.
  - aph_lock (1 bit) and lock_sel ∈ {I, D}.
  - starve_cnt (W_STARVE bits).
  - All reset to NONE / 0 / I / 0 on a clk edge with rst_n=0.
- While rst_n=0, all outputs are forced:
  - htrans=IDLE.
  - aph_ready_*, dph_ready_*, dph_err_*, dph_exokay_d = 0.
- Grant selection is combinational, in this priority order:
  1. If aph_lock, grant = lock_sel.
  2. Else if aph_req_i && (aph_panic_i || (STARVE_LIMIT>0 && starve_cnt>=STARVE_LIMIT)), grant = I.
  3. Else if aph_req_d, grant = D.
  4. Else if aph_req_i, grant = I.
  5. Else no grant.
- Address-phase outputs:
  - htrans = NSEQ (2'b10) when the granted requester's aph_req is high, else IDLE (2'b00).
  - haddr, hsize and priv come from the granted side.
  - hwrite = grant==D && hwrite_d.
  - hexcl = grant==D && aph_excl_d.
  - hprot = {2'b00, priv, grant==D}.
  - hburst = 0, hmastlock = 0.
- aph_ready_x = hready && htrans==NSEQ && grant==x. Zero-wait: accepted in the same cycle as presented.
- Lock:
  - When htrans=NSEQ and hready=0, the next state is aph_lock=1, lock_sel=grant.
  - When hready=1, aph_lock clears.
  - A late higher-priority request (including panic) never changes a stalled address phase.
  - If the locked requester drops its request while locked (legal only in the first cycle of an error response), htrans goes IDLE and the lock clears on the next hready=1.
- dph_owner: when hready=1, it loads the accepted side (I or D), or NONE if htrans=IDLE. When hready=0, it holds.
- Data-phase responses:
  - dph_ready_x = hready && dph_owner==x.
  - dph_err_i = hready && hresp && dph_owner==I.
  - dph_err_d = hresp && dph_owner==D, reported in both error cycles so the core can squash a chasing D access.
  - dph_exokay_d = hexokay && dph_owner==D.
- Data routing: rdata_i = rdata_d = hrdata, and hwdata = wdata_d, all unregistered.
- starve_cnt:
  - Increments, saturating at 2^W_STARVE−1, on each cycle with aph_ready_d=1 while aph_req_i=1.
  - Clears on aph_ready_i=1.
  - Otherwise holds.
- Simultaneous I and D requests with no lock, no panic and starve_cnt<STARVE_LIMIT: D wins, and I waits with aph_ready_i=0.
- Back-to-back transfers from different owners are fully pipelined: address phase of one overlaps the data phase of the other, with no idle insertion.

Test Plan:
- Reset, then aph_req_i=1, haddr_i=0x100, hready=1:
  - htrans=2'b10, haddr=0x100, hprot=4'b0010 (priv_i=1), aph_ready_i=1.
  - Next cycle dph_ready_i=1 and rdata_i=hrdata.
- Both requesting, aph_req_d=1 with haddr_d=0x2000 and hwrite_d=1, aph_req_i=1, STARVE_LIMIT=4, hready=1:
  - D is granted 4 consecutive cycles.
  - On the 5th cycle I is granted and starve_cnt returns to 0.
- I presented at 0x40 with hready=0 for 3 cycles; D requests and aph_panic_i toggles meanwhile:
  - haddr stays 0x40 and htrans stays NSEQ throughout.
  - aph_ready_i pulses only when hready=1.
- D load in data phase, hresp=1/hready=0 then hresp=1/hready=1:
  - dph_err_d=1 in both cycles.
  - dph_ready_d=1 only in the second cycle.
  - dph_err_i stays 0.
- Exclusive D access with aph_excl_d=1 and hexokay=1 in the data phase:
  - hexcl=1 in the address phase.
  - dph_exokay_d=1 with dph_ready_d=1.
- rst_n=0 asserted mid-stall (hready=0, lock set):
  - Next cycle htrans=IDLE, dph_owner=NONE, all handshake outputs 0.
  - After release, a fresh I request is granted normally.
